// File: rtl/parity_frame_checker_if.sv
// Bus bundle for parity_frame_checker.
// master: the side that produces the serial stream (testbench / upstream generator).
// slave: the checker.
interface parity_frame_checker_if #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 4
);
  logic              bit_en;
  logic              sdin;
  logic [DATA_W-1:0] data_out;
  logic              frame_done;
  logic              parity_err;
  logic              framing_err;
  logic [CNT_W-1:0]  err_count;
  logic              busy;

  modport master (
    output bit_en, sdin,
    input  data_out, frame_done, parity_err, framing_err, err_count, busy
  );

  modport slave (
    input  bit_en, sdin,
    output data_out, frame_done, parity_err, framing_err, err_count, busy
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Serial frame receiver/checker.
// Frame format: start(0), DATA_W data bits LSB first, parity, stop(1).
// One bit is consumed per cycle with bit_en=1. The checker rebuilds the word,
// checks parity and the stop bit, and keeps a saturating error count.
module parity_frame_checker #(
  parameter int DATA_W = 3,
  parameter bit ODD    = 1'b1,
  parameter int CNT_W  = 4
) (
  input logic                   clk,
  input logic                   rst,
  parity_frame_checker_if.slave bus
);

  localparam int              BC_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q,    state_d;
  logic [BC_W-1:0]   bcnt_q,     bcnt_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic              acc_q,      acc_d;
  logic              perr_q,     perr_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic              done_q,     done_d;
  logic              perr_out_q, perr_out_d;
  logic              ferr_q,     ferr_d;
  logic [CNT_W-1:0]  ecnt_q,     ecnt_d;
  logic              busy_q,     busy_d;

  // Next-state and result logic; nothing advances unless bit_en qualifies sdin.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    perr_d     = perr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    ecnt_d     = ecnt_q;

    if (bus.bit_en) begin
      case (state_q)
        IDLE: begin
          // Any 0 starts a frame; glitches surface later as framing errors.
          if (!bus.sdin) begin
            state_d = DATA;
            bcnt_d  = '0;
            acc_d   = 1'b0;
            shift_d = '0;
          end
        end
        DATA: begin
          shift_d[bcnt_q] = bus.sdin;
          acc_d           = acc_q ^ bus.sdin;
          if (bcnt_q == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        PARITY: begin
          perr_d  = (bus.sdin != (acc_q ^ ODD));
          state_d = STOP;
        end
        STOP: begin
          state_d    = IDLE;
          data_d     = shift_q;
          done_d     = 1'b1;
          perr_out_d = perr_q;
          ferr_d     = ~bus.sdin;
          // A frame with both errors still counts once.
          if ((perr_q || !bus.sdin) && (ecnt_q != '1)) begin
            ecnt_d = ecnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      shift_q    <= '0;
      acc_q      <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      ecnt_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      ecnt_q     <= ecnt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.frame_done  = done_q;
  assign bus.parity_err  = perr_out_q;
  assign bus.framing_err = ferr_q;
  assign bus.err_count   = ecnt_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench for parity_frame_checker.
module tb_parity_frame_checker;

  localparam int DW    = 3;
  localparam int CW    = 4;
  localparam bit ODD_P = 1'b1;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
    logic [CW-1:0] cnt;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_frame_checker_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  parity_frame_checker #(.DATA_W(DW), .ODD(ODD_P), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  frame_t obs_q[$];
  frame_t exp_q[$];
  int     n_cmp  = 0;
  int     n_fail = 0;
  int     model_errs = 0;

  // Record every frame_done pulse away from the active edge.
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1)
      obs_q.push_back({bus.data_out, bus.parity_err, bus.framing_err, bus.err_count});
  end

  // Reference model: frame result from the parity rule and stop bit.
  task automatic model_frame(input logic [DW-1:0] d, input logic p, input logic stop);
    frame_t e;
    int     ones;
    ones   = $countones(d) + int'(p);
    e.data = d;
    e.perr = ((ones % 2) == 1) != ODD_P;
    e.ferr = !stop;
    if ((e.perr || e.ferr) && model_errs < CMAX) model_errs++;
    e.cnt  = CW'(model_errs);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic en, input logic d);
    @(posedge clk);
    #1;
    bus.bit_en = en;
    bus.sdin   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop,
                            input int maxgap);
    logic [DW+2:0] bits;
    bits = {stop, p, d, 1'b0};
    model_frame(d, p, stop);
    for (int i = 0; i < DW + 3; i++) begin
      cyc(1'b1, bits[i]);
      repeat ($urandom_range(0, maxgap)) cyc(1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.bit_en = 1'b0;
    bus.sdin   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_errs = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.frame_done, bus.parity_err, bus.framing_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.busy, bus.frame_done, bus.parity_err, bus.framing_err});
    end
    n_cmp++;
    if (bus.data_out !== '0 || bus.err_count !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: data_out=%b err_count=%0d want 0/0", bus.data_out, bus.err_count);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_busy: cycle %0d got %b want 0", i, bus.busy);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0 || bus.err_count !== '0 || bus.data_out !== '0) begin
      n_fail++;
      $display("FAIL idle_quiet: frames=%0d err_count=%0d data_out=%b want 0/0/000",
               obs_q.size(), bus.err_count, bus.data_out);
    end
  endtask

  task automatic test_good_frame();
    send_frame(3'b101, 1'b1, 1'b1, 0);
    idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL good_count: got %0d frames want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      frame_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL good_frame: got d=%b pe=%b fe=%b c=%0d want d=%b pe=%b fe=%b c=%0d",
                 o.data, o.perr, o.ferr, o.cnt, e.data, e.perr, e.ferr, e.cnt);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_parity_sweep();
    send_frame(3'b101, 1'b0, 1'b1, 0);
    for (int v = 0; v < 8; v++) begin
      logic [DW-1:0] d;
      d = DW'(v);
      send_frame(d, 1'(($countones(d) % 2) == 0), 1'b1, 0);
    end
    idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL sweep_count: got %0d frames want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      frame_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sweep_frame: got d=%b pe=%b fe=%b c=%0d want d=%b pe=%b fe=%b c=%0d",
                 o.data, o.perr, o.ferr, o.cnt, e.data, e.perr, e.ferr, e.cnt);
      end
    end
    n_cmp++;
    if (bus.err_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL sweep_errcnt: got %0d want 1", bus.err_count);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_framing_gated();
    logic [DW+2:0] bits;
    bits = '0;
    model_frame(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < DW + 3; i++) begin
      cyc(1'b1, bits[i]);
      for (int g = 0; g < 3; g++) begin
        cyc(1'b0, 1'($urandom_range(0, 1)));
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== (i < DW + 2)) begin
          n_fail++;
          $display("FAIL gated_busy: bit %0d gap %0d got %b want %b", i, g, bus.busy, (i < DW + 2));
        end
      end
    end
    idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL gated_count: got %0d frames want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      frame_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL gated_frame: got d=%b pe=%b fe=%b c=%0d want d=%b pe=%b fe=%b c=%0d",
                 o.data, o.perr, o.ferr, o.cnt, e.data, e.perr, e.ferr, e.cnt);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++) begin
      logic [DW-1:0] d;
      d = DW'($urandom_range(0, 7));
      send_frame(d, 1'($countones(d) % 2), 1'b1, 0);
    end
    idle(3);
    n_cmp++;
    if (obs_q.size() != 20) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d frames want 20", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      frame_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b_frame: got d=%b pe=%b fe=%b c=%0d want d=%b pe=%b fe=%b c=%0d",
                 o.data, o.perr, o.ferr, o.cnt, e.data, e.perr, e.ferr, e.cnt);
      end
    end
    n_cmp++;
    if (bus.err_count !== CW'(CMAX)) begin
      n_fail++;
      $display("FAIL b2b_saturate: got %0d want %0d", bus.err_count, CMAX);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    do_reset();
    idle(8);
    @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0 || bus.err_count !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abandon: frames=%0d err_count=%0d busy=%b want 0/0/0",
               obs_q.size(), bus.err_count, bus.busy);
    end
    send_frame(3'b011, 1'b1, 1'b1, 0);
    idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d frames want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      frame_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midreset_frame: got d=%b pe=%b fe=%b c=%0d want d=%b pe=%b fe=%b c=%0d",
                 o.data, o.perr, o.ferr, o.cnt, e.data, e.perr, e.ferr, e.cnt);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      send_frame(DW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 2);
      idle($urandom_range(0, 2));
    end
    idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d frames want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      frame_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random_frame: got d=%b pe=%b fe=%b c=%0d want d=%b pe=%b fe=%b c=%0d",
                 o.data, o.perr, o.ferr, o.cnt, e.data, e.perr, e.ferr, e.cnt);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    bus.bit_en = 1'b0;
    bus.sdin   = 1'b1;
    test_reset();
    test_good_frame();
    test_parity_sweep();
    test_framing_gated();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Serial receiver and checker placed directly downstream of the 3-bit parity generator.
- Accepts a framed bit stream (start, DATA_W data bits LSB first, parity bit, stop), one bit per enabled cycle.
- Rebuilds the data word, recomputes parity, and flags parity and framing errors.
- Keeps a saturating error counter for the lab display.

Parameters:
- DATA_W, 3, number of data bits per frame (a0 first, then a1, then a2).
- ODD, 1, 1 = odd parity (data+parity has odd number of ones, i.e. parity = ~(a0^a1^a2)); 0 = even parity.
- CNT_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- bit_en  input  1  qualifies sdin; a bit is sampled only on cycles where bit_en=1.
- sdin  input  1  serial line; idle level 1.
- data_out  output  DATA_W  last received data word; held until the next frame completes.
- frame_done  output  1  one-cycle pulse when a frame finishes (good or bad).
- parity_err  output  1  valid with frame_done; 1 = recomputed parity ≠ received parity bit.
- framing_err  output  1  valid with frame_done; 1 = stop bit sampled as 0.
- err_count  output  CNT_W  frames with parity_err or framing_err; saturates at all-ones.
- busy  output  1  1 while the FSM is not in IDLE.

Behaviour:
- Reset is synchronous and active-high, on rst. On reset:
  - FSM goes to IDLE.
  - data_out, frame_done, parity_err, framing_err, err_count, the bit counter and the shift register all go to 0.
  - rst mid-frame abandons the frame with no frame_done and no counter change.
- The FSM advances only on cycles with bit_en=1. When bit_en=0, all state holds and frame_done is 0.
- IDLE:
  - sdin=0 → DATA, with bit counter cleared and the running parity accumulator set to 0.
  - sdin=1 → stay in IDLE.
- DATA:
  - Shift sdin into bit position [count], LSB first, and XOR it into the accumulator.
  - After DATA_W bits → PARITY.
- PARITY: sample the parity bit p → STOP.
  - Expected p = acc ^ ODD.
  - Record perr = (p ≠ expected).
- STOP: sample the stop bit, return to IDLE, and on that same edge:
  - data_out ← shift register.
  - frame_done ← 1 for one cycle.
  - parity_err ← perr.
  - framing_err ← ~sdin.
  - err_count increments if (perr | ~sdin) and it is not already all-ones.
- Latency: frame_done, data_out and the error flags are visible the cycle after the edge that samples the stop bit.
- parity_err and framing_err hold their values until the next frame_done. They are meaningful only when frame_done=1.
- A new start bit may be sampled on the very next enabled cycle after STOP. Back-to-back frames are allowed with no idle gap.
- A false start (a 0 glitch) is not filtered. It is treated as a frame, and any error shows up through framing_err.
- busy = (state ≠ IDLE), registered with the state.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then sdin=1 with bit_en=1 for 10 cycles → busy=0, frame_done never 1, err_count=0, data_out=000.
- Good frame, ODD=1: bits 0,1,0,1,1,1 (start, a0=1, a1=0, a2=1, parity=1, stop), bit_en=1 each cycle → frame_done pulses once, data_out=3'b101, parity_err=0, framing_err=0, err_count=0.
- Parity error: same frame with parity bit 0 → data_out=3'b101, parity_err=1, framing_err=0, err_count=1. Sweep all 8 data values with the correct parity afterwards → all 8 clean, err_count stays 1.
- Framing error plus gated bit_en:
  - Frame 0,0,0,0,0,0 (data 000, parity 0 is wrong for odd, stop 0), with bit_en=0 inserted for 3 cycles between each bit.
  - → parity_err=1 and framing_err=1 on a single frame_done.
  - → err_count +1 (not +2).
  - → state holds during the bit_en=0 gaps.
- Saturation and back-to-back: 20 consecutive bad frames with no idle gap, CNT_W=4 → err_count reaches 15 and stays at 15. Exactly 20 frame_done pulses.
- Reset mid-frame: assert rst after start + 2 data bits → no frame_done, err_count=0. A following good frame with data 3'b011 and parity 1 (two ones, so odd parity needs p=1) → data_out=3'b011, no errors.
